cost_arb: RTL and testbench
===========================

COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (fixed 4 in this release).
REQ-002 The block SHALL have parameter MAXBURST, default 8, giving the maximum number of consecutive locked grants.
REQ-003 CLK  input  1  the single clock; all flops clock on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 REQ  input  4  per-requester lookup request; held until granted.
REQ-006 LOCK  input  4  per-requester burst-lock request, qualified by REQ.
REQ-007 REQ_W  input  12  worker index, 3 bits per requester; requester i uses bits [3i+2:3i].
REQ-008 REQ_J  input  12  job index, 3 bits per requester, same packing as REQ_W.
REQ-009 GNT  output  4  combinational one-hot grant; the request is accepted in the cycle GNT[i]=1.
REQ-010 W  output  3  registered worker index to the cost table.
REQ-011 J  output  3  registered job index to the cost table.
REQ-012 Cost  input  7  cost-table read data, valid in the cycle after W/J update.
REQ-013 RVALID  output  4  registered one-hot response strobe.
REQ-014 RDATA  output  7  registered cost for the strobed requester.

Function
REQ-015 GNT SHALL be one-hot or zero, with at most one grant per cycle and a throughput of one lookup per cycle.
REQ-016 The FSM SHALL have two states: ARB (round-robin) and BURST (single owner locked).
REQ-017 ARB: GNT SHALL go to the first requester with REQ=1, searching upward (mod 4) from LAST+1, where LAST is the last granted index.
REQ-018 ARB -> BURST SHALL occur when the granted requester has LOCK=1 and MAXBURST>1; OWNER is set to that index and BCNT to 1.
REQ-019 BURST: GNT[OWNER] SHALL equal REQ[OWNER], and all other requesters SHALL receive no grant.
REQ-020 BURST: each grant SHALL increment BCNT.
REQ-021 BURST: the FSM SHALL return to ARB after a grant with LOCK[OWNER]=0, after a grant that brings BCNT to MAXBURST, or in any cycle with REQ[OWNER]=0; in the REQ[OWNER]=0 case no grant is issued that cycle.
REQ-022 LAST SHALL update to the granted index on every grant, so that after a burst the next ARB search starts at OWNER+1.
REQ-023 On a grant to requester i, W SHALL take REQ_W[i] and J SHALL take REQ_J[i] at the next edge, and a 2-stage tag pipeline SHALL record i.
REQ-024 Latency: a grant in cycle t SHALL produce W/J in t+1 (Cost sampled at the end of t+1) and RVALID[i]=1 with RDATA=Cost in t+2.
REQ-025 W/J SHALL hold their previous value in cycles without a grant.
REQ-026 RVALID SHALL be all-zero in any cycle whose stage-2 tag is empty.
REQ-027 Back-to-back grants to different requesters SHALL yield back-to-back RVALID in grant order, with no reordering.
REQ-028 A change of REQ_W/REQ_J while a request is not yet granted is legal; only the value at grant is used.
REQ-029 LOCK without REQ SHALL be ignored.
REQ-030 LOCK dropping in the middle of a burst SHALL take effect on the next grant.
REQ-031 MAXBURST=1 SHALL make LOCK a no-op.
REQ-032 BCNT SHALL be wide enough for MAXBURST without wrap.

Reset
REQ-033 RST_N=0 SHALL asynchronously force state ARB, LAST=3 (requester 0 highest priority), BCNT=0, OWNER=0, W=0, J=0, RVALID=0, RDATA=0, and both tag stages empty.
REQ-034 GNT SHALL be 0 while RST_N=0.
REQ-035 Reset asserted mid-burst or with lookups in flight SHALL discard those responses, with no RVALID after release.
REQ-036 The first cycle after reset release SHALL arbitrate normally.

Verification
REQ-037 Reset release, REQ=4'b1111, LOCK=0 -> GNT sequence 0001, 0010, 0100, 1000, 0001; RVALID follows two cycles later in the same order.
REQ-038 REQ[2]=1 only, REQ_W[2]=5, REQ_J[2]=3, table entry (5,3)=42 -> GNT[2] in cycle t, W=5/J=3 in t+1, RVALID=0100 and RDATA=42 in t+2.
REQ-039 REQ=1111, LOCK[1]=1 held -> 8 consecutive grants to requester 1, then forced release and the next grant to requester 2; other requesters are never granted mid-burst.
REQ-040 Burst by requester 3 with LOCK[3] dropped on the 3rd grant -> exactly 3 grants to requester 3, then requester 0 is granted.
REQ-041 Burst owner drops REQ after 2 grants while REQ[0]=1 -> one idle cycle with GNT=0, then requester 0 is granted.
REQ-042 RST_N pulsed low with 2 lookups in flight -> RVALID stays 0 throughout; after release the arbitration restarts at requester 0.

Source files
------------

// File: rtl/cost_arb_if.sv
// rtl/cost_arb_if.sv - request/grant and cost-table bundle for cost_arb
interface cost_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [3*NREQ-1:0] req_w;
    logic [3*NREQ-1:0] req_j;
    logic [NREQ-1:0]   gnt;
    logic [2:0]        w;
    logic [2:0]        j;
    logic [6:0]        cost;
    logic [NREQ-1:0]   rvalid;
    logic [6:0]        rdata;

    modport master (
        output req, lock, req_w, req_j, cost,
        input  gnt, w, j, rvalid, rdata
    );

    modport slave (
        input  req, lock, req_w, req_j, cost,
        output gnt, w, j, rvalid, rdata
    );
endinterface

// File: rtl/cost_arb.sv
// rtl/cost_arb.sv - round-robin cost-table lookup arbiter with burst lock
// Grants one requester per cycle, drives W/J next cycle, returns Cost two cycles after grant.
module cost_arb #(
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    cost_arb_if.slave bus
);
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {ARB, BURST} state_e;

    state_e          state_q;
    logic [1:0]      last_q;
    logic [1:0]      owner_q;
    logic [BW-1:0]   bcnt_q;
    logic [BW-1:0]   bcnt_d;
    logic [2:0]      w_q;
    logic [2:0]      j_q;
    logic            tag1_vld_q;
    logic [1:0]      tag1_idx_q;
    logic [NREQ-1:0] rvalid_q;
    logic [6:0]      rdata_q;

    logic            gnt_vld;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = owner_q;
        cand    = '0;
        if (state_q == BURST) begin
            gnt_vld = bus.req[owner_q];
        end else begin
            // descending scan: the last hit is the nearest requester above last_q
            for (int k = NREQ; k >= 1; k--) begin
                cand = last_q + 2'(k);
                if (bus.req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign bcnt_d     = bcnt_q + BW'(1);
    assign bus.gnt    = (gnt_vld && rst_n_i) ? (NREQ'(1) << gnt_idx) : '0;
    assign bus.w      = w_q;
    assign bus.j      = j_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ARB;
            last_q     <= 2'd3;
            owner_q    <= '0;
            bcnt_q     <= '0;
            w_q        <= '0;
            j_q        <= '0;
            tag1_vld_q <= 1'b0;
            tag1_idx_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            if (gnt_vld) begin
                last_q <= gnt_idx;
                w_q    <= bus.req_w[3*gnt_idx +: 3];
                j_q    <= bus.req_j[3*gnt_idx +: 3];
            end
            tag1_vld_q <= gnt_vld;
            tag1_idx_q <= gnt_idx;
            // stage 2 of the tag pipeline is the response strobe itself
            rvalid_q   <= tag1_vld_q ? (NREQ'(1) << tag1_idx_q) : '0;
            if (tag1_vld_q) begin
                rdata_q <= bus.cost;
            end

            case (state_q)
                ARB: begin
                    if (gnt_vld && bus.lock[gnt_idx] && (MAXBURST > 1)) begin
                        state_q <= BURST;
                        owner_q <= gnt_idx;
                        bcnt_q  <= BW'(1);
                    end
                end
                BURST: begin
                    if (!bus.req[owner_q]) begin
                        state_q <= ARB;
                        bcnt_q  <= '0;
                    end else if (!bus.lock[owner_q] || (bcnt_d == BW'(MAXBURST))) begin
                        state_q <= ARB;
                        bcnt_q  <= '0;
                    end else begin
                        bcnt_q  <= bcnt_d;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_cost_arb.sv
// tb/tb_cost_arb.sv - self-checking bench for cost_arb
module tb_cost_arb;
    localparam int MAXB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cost_arb_if #(.NREQ(4)) bus ();

    cost_arb #(.NREQ(4), .MAXBURST(MAXB)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    logic [6:0] cost_tab [0:63];
    assign bus.cost = cost_tab[{bus.w, bus.j}];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         due;
        int         idx;
        logic [6:0] cost;
    } resp_t;

    resp_t      rq[$];
    bit         m_burst = 0;
    int         m_owner = 0;
    int         m_cnt   = 0;
    int         m_last  = 3;
    int         cyc     = 0;
    logic [2:0] exp_w   = '0;
    logic [2:0] exp_j   = '0;
    logic [3:0] exp_rv  = '0;
    logic [6:0] exp_rd  = '0;

    function automatic int model_gnt();
        if (!rst_n) return -1;
        if (m_burst) return bus.req[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (bus.req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int    g;
        resp_t r;
        if (!rst_n) begin
            m_burst = 0; m_owner = 0; m_cnt = 0; m_last = 3; cyc = 0;
            rq.delete();
            exp_w = '0; exp_j = '0; exp_rv = '0; exp_rd = '0;
        end else begin
            g = model_gnt();
            if (!m_burst) begin
                if (g >= 0 && bus.lock[g] && MAXB > 1) begin
                    m_burst = 1; m_owner = g; m_cnt = 1;
                end
            end else if (!bus.req[m_owner]) begin
                m_burst = 0;
            end else begin
                m_cnt++;
                if (!bus.lock[m_owner] || m_cnt == MAXB) m_burst = 0;
            end
            if (g >= 0) begin
                m_last = g;
                exp_w  = bus.req_w[3*g +: 3];
                exp_j  = bus.req_j[3*g +: 3];
                r.due  = cyc + 2;
                r.idx  = g;
                r.cost = cost_tab[{exp_w, exp_j}];
                rq.push_back(r);
            end
            cyc++;
            exp_rv = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_rv = onehot(rq[0].idx);
                exp_rd = rq[0].cost;
                void'(rq.pop_front());
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] l);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.lock = l;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        bus.req_w = '0;
        bus.req_j = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.gnt !== 4'h0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        total++; if (bus.rvalid !== 4'h0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0000", bus.rvalid); end
        total++; if (bus.rdata !== 7'd0) begin bad++; $display("FAIL reset_rdata got=%0d exp=0", bus.rdata); end
        total++; if (bus.w !== 3'd0 || bus.j !== 3'd0) begin bad++; $display("FAIL reset_wj got=%0d/%0d exp=0/0", bus.w, bus.j); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg  [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
        logic [3:0] erv [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                if (c == 5) bus.req = '0;
            end
            @(negedge clk);
            total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
            total++; if (bus.rvalid !== erv[c]) begin bad++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, bus.rvalid, erv[c]); end
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0100, 4'b0000);
        bus.req_w = 12'(5 << 6);
        bus.req_j = 12'(3 << 6);
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt); end
        drive(4'b0000, 4'b0000);
        bus.req_w = '0;
        bus.req_j = '0;
        @(negedge clk);
        total++; if (bus.w !== 3'd5 || bus.j !== 3'd3) begin bad++; $display("FAIL single_wj got=%0d/%0d exp=5/3", bus.w, bus.j); end
        total++; if (bus.rvalid !== 4'b0000) begin bad++; $display("FAIL single_rv_early got=%b exp=0000", bus.rvalid); end
        drive(4'b0000, 4'b0000);
        @(negedge clk);
        total++; if (bus.rvalid !== 4'b0100) begin bad++; $display("FAIL single_rvalid got=%b exp=0100", bus.rvalid); end
        total++; if (bus.rdata !== 7'd42) begin bad++; $display("FAIL single_rdata got=%0d exp=42", bus.rdata); end
        total++; if (bus.w !== 3'd5) begin bad++; $display("FAIL single_w_hold got=%0d exp=5", bus.w); end
    endtask

    task automatic test_burst_max();
        logic [3:0] eg;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(4'hF, 4'b0010);
            eg = (c == 0) ? 4'b0001 : (c == 9) ? 4'b0100 : 4'b0010;
            @(negedge clk);
            total++; if (bus.gnt !== eg) begin bad++; $display("FAIL burst_max c=%0d got=%b exp=%b", c, bus.gnt, eg); end
        end
    endtask

    task automatic test_lock_drop();
        logic [3:0] rr [4] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001};
        logic [3:0] ll [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] eg [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(rr[c], ll[c]);
            @(negedge clk);
            total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL lock_drop c=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
        end
    endtask

    task automatic test_req_drop();
        logic [3:0] rr [4] = '{4'b0100, 4'b0101, 4'b0001, 4'b0001};
        logic [3:0] eg [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(rr[c], 4'b0100);
            @(negedge clk);
            total++; if (bus.gnt !== eg[c]) begin bad++; $display("FAIL req_drop c=%0d got=%b exp=%b", c, bus.gnt, eg[c]); end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        drive(4'b0011, 4'b0000);
        drive(4'b0011, 4'b0000);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        bus.req = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (bus.rvalid !== 4'h0 || bus.gnt !== 4'h0) begin bad++; $display("FAIL inflight_rst c=%0d rvalid=%b gnt=%b exp=0000/0000", c, bus.rvalid, bus.gnt); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL inflight_restart got=%b exp=0001", bus.gnt); end
        total++; if (bus.rvalid !== 4'h0) begin bad++; $display("FAIL inflight_rv0 got=%b exp=0000", bus.rvalid); end
        drive(4'hF, 4'h0);
        @(negedge clk);
        total++; if (bus.rvalid !== 4'h0) begin bad++; $display("FAIL inflight_rv1 got=%b exp=0000", bus.rvalid); end
        drive(4'hF, 4'h0);
        @(negedge clk);
        total++; if (bus.rvalid !== 4'b0001) begin bad++; $display("FAIL inflight_rv2 got=%b exp=0001", bus.rvalid); end
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] l;
        int         g;
        pend = '0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) pend[i] = 1'b1;
                l[i] = (n < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            end
            drive(pend, l);
            bus.req_w = 12'($urandom);
            bus.req_j = 12'($urandom);
            @(negedge clk);
            g = model_gnt();
            total++; if (bus.gnt !== onehot(g)) begin bad++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, bus.gnt, onehot(g)); end
            total++; if (bus.w !== exp_w || bus.j !== exp_j) begin bad++; $display("FAIL rnd_wj n=%0d got=%0d/%0d exp=%0d/%0d", n, bus.w, bus.j, exp_w, exp_j); end
            total++; if (bus.rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, bus.rvalid, exp_rv); end
            total++; if (bus.rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata n=%0d got=%0d exp=%0d", n, bus.rdata, exp_rd); end
            if (g >= 0) pend[g] = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) cost_tab[i] = 7'($urandom);
        cost_tab[43] = 7'd42;
        bus.req   = '0;
        bus.lock  = '0;
        bus.req_w = '0;
        bus.req_j = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_burst_max();
        test_lock_drop();
        test_req_drop();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
